lsu_mem_access: RTL

- Load/store unit on the consumer side of the execute stage.
- Accepts a memory operation carrying the ALU-computed effective address, store data and width code.
- Drives a single-outstanding request/acknowledge data-memory bus, then returns an aligned, sign/zero-extended load result or a store completion to writeback.
- Stalls the pipeline while a bus access is in flight; flags misaligned and illegal accesses and bus timeouts.

---
 rtl/lsu_mem_access_if.sv | 28 ++
 rtl/lsu_mem_access.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_access_if.sv
// Data-memory bus between the load/store unit and memory.
// One request is outstanding at a time. mem_req is held high until mem_ack
// arrives or the LSU gives up on the access. mem_rdata is valid in the
// same cycle as mem_ack.
//   master : LSU side. It drives the request, write enable, address, strobes
//            and write data, and receives ack and read data.
//   slave  : memory side.
interface lsu_mem_access_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_access.sv
// Load/store unit placed after the execute stage.
// It takes one memory operation at a time: the effective address, the store
// data and a width/sign code. It runs a single bus access through the bus
// interface and returns either an extended load result or a store completion
// on the writeback port.
// Ports:
//   clk, rst_n        : clock and synchronous active-low reset
//   req_valid/ready   : operation handshake. req_ready is high only in IDLE.
//   rmem, wmem        : load / store select
//   funct3            : 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, wdata       : effective address and store data
//   rd_addr           : load destination register
//   bus               : data-memory bus (master side)
//   wb_*              : one-cycle completion pulse with result
//   stall             : req_valid held off by a busy LSU (combinational)
//   exc_misalign      : pulse for a misaligned or illegal operation
//   exc_bus           : pulse when the bus access times out
module lsu_mem_access #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              rmem,
  input  logic              wmem,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [4:0]        rd_addr,
  lsu_mem_access_if.master  bus,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              stall,
  output logic              exc_misalign,
  output logic              exc_bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  // Operation fields captured at accept and used when the access completes.
  logic              rmem_reg, rmem_next;
  logic [2:0]        funct3_reg, funct3_next;
  logic [1:0]        off_reg, off_next;
  logic [4:0]        rd_reg, rd_next;

  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [3:0]        mem_wstrb_reg, mem_wstrb_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;

  logic              wb_valid_reg, wb_valid_next;
  logic              wb_we_reg, wb_we_next;
  logic [4:0]        wb_rd_reg, wb_rd_next;
  logic [31:0]       wb_data_reg, wb_data_next;
  logic              exc_misalign_reg, exc_misalign_next;
  logic              exc_bus_reg, exc_bus_next;

  // An operation is rejected for any of these reasons: it is neither a load
  // nor a store, or it is both; it uses a reserved width code; it is a store
  // with an unsigned width code; or its address is not aligned to its size.
  logic op_illegal;
  logic op_misalign;
  logic op_reject;

  assign op_illegal  = (rmem == wmem) || (funct3 == 3'b011) ||
                       (funct3[2:1] == 2'b11) || (wmem && funct3[2]);
  assign op_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign op_reject   = op_illegal || op_misalign;

  // Store data is copied into every byte lane. The memory only writes the
  // lanes that the strobes select, so the replication is harmless.
  logic [3:0][7:0] st_lane;
  logic [31:0]     st_data;
  logic [3:0]      st_strb;

  for (genvar gi = 0; gi < 4; gi++) begin : g_st_lane
    always_comb begin
      case (funct3[1:0])
        2'b00:   st_lane[gi] = wdata[7:0];
        2'b01:   st_lane[gi] = wdata[8*(gi%2) +: 8];
        default: st_lane[gi] = wdata[8*gi +: 8];
      endcase
    end
  end
  assign st_data = st_lane;

  always_comb begin
    case (funct3[1:0])
      2'b00:   st_strb = 4'b0001 << addr[1:0];
      2'b01:   st_strb = 4'b0011 << addr[1:0];
      default: st_strb = 4'b1111;
    endcase
  end

  // Load result: bring the addressed byte or halfword down to bit 0, then
  // extend it.
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  assign ld_shift = bus.mem_rdata >> {off_reg, 3'b000};

  always_comb begin
    case (funct3_reg)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    rmem_next         = rmem_reg;
    funct3_next       = funct3_reg;
    off_next          = off_reg;
    rd_next           = rd_reg;
    mem_req_next      = mem_req_reg;
    mem_we_next       = mem_we_reg;
    mem_addr_next     = mem_addr_reg;
    mem_wstrb_next    = mem_wstrb_reg;
    mem_wdata_next    = mem_wdata_reg;
    wb_valid_next     = 1'b0;
    wb_we_next        = 1'b0;
    wb_rd_next        = wb_rd_reg;
    wb_data_next      = wb_data_reg;
    exc_misalign_next = 1'b0;
    exc_bus_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (op_reject) begin
            // Report the rejection on the writeback port without touching
            // the bus, so that the pipeline can retire the instruction.
            exc_misalign_next = 1'b1;
            wb_valid_next     = 1'b1;
            wb_rd_next        = rd_addr;
            wb_data_next      = 32'd0;
          end else begin
            rmem_next      = rmem;
            funct3_next    = funct3;
            off_next       = addr[1:0];
            rd_next        = rd_addr;
            mem_req_next   = 1'b1;
            mem_we_next    = wmem;
            mem_addr_next  = {addr[ADDR_W-1:2], 2'b00};
            mem_wstrb_next = wmem ? st_strb : 4'b0000;
            mem_wdata_next = st_data;
            cnt_next       = '0;
            state_next     = BUSY;
          end
        end
      end

      BUSY: begin
        // The ack is tested before the timeout. If both happen in the same
        // cycle, the access completes normally.
        if (bus.mem_ack) begin
          mem_req_next  = 1'b0;
          wb_valid_next = 1'b1;
          wb_we_next    = rmem_reg;
          wb_rd_next    = rd_reg;
          wb_data_next  = rmem_reg ? ld_data : 32'd0;
          state_next    = DONE;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          mem_req_next  = 1'b0;
          exc_bus_next  = 1'b1;
          wb_valid_next = 1'b1;
          wb_rd_next    = rd_reg;
          wb_data_next  = 32'd0;
          cnt_next      = '0;
          state_next    = IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      rmem_reg         <= 1'b0;
      funct3_reg       <= 3'd0;
      off_reg          <= 2'd0;
      rd_reg           <= 5'd0;
      mem_req_reg      <= 1'b0;
      mem_we_reg       <= 1'b0;
      mem_addr_reg     <= '0;
      mem_wstrb_reg    <= 4'd0;
      mem_wdata_reg    <= 32'd0;
      wb_valid_reg     <= 1'b0;
      wb_we_reg        <= 1'b0;
      wb_rd_reg        <= 5'd0;
      wb_data_reg      <= 32'd0;
      exc_misalign_reg <= 1'b0;
      exc_bus_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      rmem_reg         <= rmem_next;
      funct3_reg       <= funct3_next;
      off_reg          <= off_next;
      rd_reg           <= rd_next;
      mem_req_reg      <= mem_req_next;
      mem_we_reg       <= mem_we_next;
      mem_addr_reg     <= mem_addr_next;
      mem_wstrb_reg    <= mem_wstrb_next;
      mem_wdata_reg    <= mem_wdata_next;
      wb_valid_reg     <= wb_valid_next;
      wb_we_reg        <= wb_we_next;
      wb_rd_reg        <= wb_rd_next;
      wb_data_reg      <= wb_data_next;
      exc_misalign_reg <= exc_misalign_next;
      exc_bus_reg      <= exc_bus_next;
    end
  end

  assign req_ready     = (state_reg == IDLE);
  assign stall         = req_valid && !req_ready;
  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wstrb = mem_wstrb_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign wb_valid      = wb_valid_reg;
  assign wb_we         = wb_we_reg;
  assign wb_rd         = wb_rd_reg;
  assign wb_data       = wb_data_reg;
  assign exc_misalign  = exc_misalign_reg;
  assign exc_bus       = exc_bus_reg;

endmodule
